q_update_engine: RTL

Temporal-difference update engine for the Q-table: on `start`, it reads Q(s) and Q(s') from the action RAM and computes Q_new = Q(s) + alpha·(reward + gamma·Q(s') − Q(s)) in signed fixed point with saturation. It then writes Q_new back to address s. It sits directly upstream of `action_ram`, driving its `st`, `st_1`, `we` and `in_data` inputs and consuming `out_qt` / `out_qt_1`.

---
 rtl/q_update_engine_if.sv | 30 +++
 rtl/q_update_engine.sv | 129 ++++++++++++
 2 files changed

// File: rtl/q_update_engine_if.sv
// q_update_engine_if
// RAM-side bus between the TD update engine and action_ram.
//   ram_st     : read address for Q(s); also the write address
//   ram_st_1   : read address for Q(s')
//   ram_we     : write enable (RAM writes on the negedge while high)
//   ram_wdata  : write data
//   ram_qt     : registered Q(s) from the RAM
//   ram_qt_1   : registered Q(s') from the RAM
// master = engine side, slave = RAM side.
interface q_update_engine_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int STATES_WIDTH = 4
);
  logic [STATES_WIDTH-1:0] ram_st;
  logic [STATES_WIDTH-1:0] ram_st_1;
  logic                    ram_we;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_qt;
  logic [DATA_WIDTH-1:0]   ram_qt_1;

  modport master (
    output ram_st, ram_st_1, ram_we, ram_wdata,
    input  ram_qt, ram_qt_1
  );

  modport slave (
    input  ram_st, ram_st_1, ram_we, ram_wdata,
    output ram_qt, ram_qt_1
  );
endinterface

// File: rtl/q_update_engine.sv
// q_update_engine
// Temporal-difference update for one Q-table entry:
//   Q_new = sat(Q(s) + alpha * sat(reward + gamma*Q(s') - Q(s)))
// in signed fixed point with FRAC_BITS fractional bits.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : request, sampled only in IDLE
//   st, st_1          : current / next state indices
//   reward/alpha/gamma: signed fixed-point operands, latched on accept
//   busy              : accept edge .. done edge
//   done              : one-cycle pulse after the write cycle
//   q_new             : last value written
//   ram               : action_ram bus (master side)
module q_update_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int STATES_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [STATES_WIDTH-1:0] st,
  input  logic [STATES_WIDTH-1:0] st_1,
  input  logic [DATA_WIDTH-1:0]   reward,
  input  logic [DATA_WIDTH-1:0]   alpha,
  input  logic [DATA_WIDTH-1:0]   gamma,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   q_new,
  q_update_engine_if.master       ram
);

  // Wide enough for reward + (product >>> FRAC_BITS) - Q without wrap.
  localparam int SUM_W = DATA_WIDTH + (DATA_WIDTH - FRAC_BITS) + 2;

  typedef enum logic [2:0] {IDLE, READ, TD, UPD, WR} state_t;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0]   reward_r, alpha_r, gamma_r;
  logic signed [DATA_WIDTH-1:0]   td_r, qt_r;
  logic signed [2*DATA_WIDTH-1:0] g_prod, a_prod;
  logic signed [SUM_W-1:0]        td_sum, upd_sum;

  // Clamp to the DATA_WIDTH signed range: in range iff all bits from the
  // result sign bit upward agree.
  function automatic logic [DATA_WIDTH-1:0] sat_w(input logic [SUM_W-1:0] x);
    if ((&x[SUM_W-1:DATA_WIDTH-1]) || ~(|x[SUM_W-1:DATA_WIDTH-1]))
      sat_w = x[DATA_WIDTH-1:0];
    else if (x[SUM_W-1])
      sat_w = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat_w = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  // Full-width products; >>> on signed operands floors toward -inf.
  always_comb begin
    g_prod  = gamma_r * $signed(ram.ram_qt_1);
    a_prod  = alpha_r * td_r;
    td_sum  = SUM_W'(reward_r) + SUM_W'(g_prod >>> FRAC_BITS)
            - SUM_W'($signed(ram.ram_qt));
    upd_sum = SUM_W'(qt_r) + SUM_W'(a_prod >>> FRAC_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = TD;
      TD:      state_d = UPD;
      UPD:     state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram.ram_st    <= '0;
      ram.ram_st_1  <= '0;
      ram.ram_we    <= 1'b0;
      ram.ram_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      q_new         <= '0;
      reward_r      <= '0;
      alpha_r       <= '0;
      gamma_r       <= '0;
      td_r          <= '0;
      qt_r          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ram.ram_st   <= st;
            ram.ram_st_1 <= st_1;
            reward_r     <= $signed(reward);
            alpha_r      <= $signed(alpha);
            gamma_r      <= $signed(gamma);
            busy         <= 1'b1;
          end
        end
        READ: ;  // RAM registers Q(s)/Q(s') on this edge
        TD: begin
          td_r <= $signed(sat_w(td_sum));
          qt_r <= $signed(ram.ram_qt);
        end
        UPD: begin
          ram.ram_wdata <= sat_w(upd_sum);
          ram.ram_we    <= 1'b1;
        end
        WR: begin
          ram.ram_we <= 1'b0;
          done       <= 1'b1;
          busy       <= 1'b0;
          q_new      <= ram.ram_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule
